hamming74_tx: RTL and testbench

Streaming Hamming(7,4) encoder and serial transmitter: the transmit end of the single-error-correcting link whose receiver holds the 7-bit corrector. Each accepted 4-bit nibble is encoded into a codeword in positions 1..7, with parity at positions 1, 2 and 4. The codeword is shifted out one bit per clock, position 1 first. A per-word error-injection input flips one chosen codeword bit so the downstream corrector can be exercised in-system.

---
 rtl/hamming74_tx_if.sv | 26 ++
 rtl/hamming74_tx.sv | 133 +++++++++++++
 tb/tb_hamming74_tx.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming74_tx_if.sv
// Purpose: bundles the nibble-in handshake and the serial/parallel codeword outputs of hamming74_tx.
// Latency: none; this file only carries wires.
// Backpressure: DIN_READY from the slave side throttles DIN_VALID on the master side.
interface hamming74_tx_if;
  logic [3:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [2:0]  INJ_POS;
  logic        SOUT;
  logic        SOUT_VALID;
  logic        SOF;
  logic [1:7]  CODE;
  logic [15:0] FRAMES;

  // Word source and link monitor.
  modport master (
    output DIN, DIN_VALID, INJ_POS,
    input  DIN_READY, SOUT, SOUT_VALID, SOF, CODE, FRAMES
  );

  // Encoder / transmitter.
  modport slave (
    input  DIN, DIN_VALID, INJ_POS,
    output DIN_READY, SOUT, SOUT_VALID, SOF, CODE, FRAMES
  );
endinterface

// File: rtl/hamming74_tx.sv
// Purpose: Hamming(7,4) encoder with per-word error injection, serialised position 1 first.
// Latency: accept on edge k -> pos1 on SOUT after edge k, pos7 after edge k+6; CODE updates at edge k.
// Backpressure: DIN_READY low while shifting (except the last bit when IDLE_GAP==0) and during the gap.
module hamming74_tx #(
  parameter int IDLE_GAP = 0
) (
  input  logic           CLK,
  input  logic           RESET,
  hamming74_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit         NO_GAP   = (IDLE_GAP == 0);
  localparam logic [3:0] GAP_INIT = 4'(IDLE_GAP);

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:7]  code_q, code_d;
  logic [15:0] frames_q, frames_d;

  logic [1:7]  enc;
  logic        din_ready;

  // Encode the offered nibble, then flip the selected position (0 selects none).
  always_comb begin
    enc    = '0;
    enc[3] = bus.DIN[0];
    enc[5] = bus.DIN[1];
    enc[6] = bus.DIN[2];
    enc[7] = bus.DIN[3];
    enc[1] = enc[3] ^ enc[5] ^ enc[7];
    enc[2] = enc[3] ^ enc[6] ^ enc[7];
    enc[4] = enc[5] ^ enc[6] ^ enc[7];
    for (int i = 1; i <= 7; i++) begin
      if (bus.INJ_POS == 3'(i)) begin
        enc[i] = ~enc[i];
      end
    end
  end

  // Next-state logic; the frame counter bump on the last bit coexists with a back-to-back reload.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    gap_d     = gap_q;
    code_d    = code_q;
    frames_d  = frames_q;
    din_ready = 1'b0;
    case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        if (bus.DIN_VALID) begin
          code_d   = enc;
          bitcnt_d = 3'd1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt_q == 3'd7) begin
          frames_d = frames_q + 16'd1;
          if (NO_GAP) begin
            din_ready = 1'b1;
            if (bus.DIN_VALID) begin
              code_d   = enc;
              bitcnt_d = 3'd1;
            end else begin
              bitcnt_d = 3'd0;
              state_d  = IDLE;
            end
          end else begin
            bitcnt_d = 3'd0;
            gap_d    = GAP_INIT;
            state_d  = GAP;
          end
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = 3'd0;
        gap_d    = 4'd0;
      end
    endcase
  end

  // State register; reset drops any partial frame without counting it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      gap_q    <= 4'd0;
      code_q   <= '0;
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      gap_q    <= gap_d;
      code_q   <= code_d;
      frames_q <= frames_d;
    end
  end

  // Serial outputs are decoded from the registered state, so they are clean from reset.
  always_comb begin
    bus.SOUT_VALID = (state_q == SHIFT);
    bus.SOUT       = 1'b0;
    bus.SOF        = 1'b0;
    if (state_q == SHIFT) begin
      bus.SOUT = code_q[bitcnt_q];
      bus.SOF  = (bitcnt_q == 3'd1);
    end
  end

  assign bus.DIN_READY = din_ready;
  assign bus.CODE      = code_q;
  assign bus.FRAMES    = frames_q;

endmodule

// File: tb/tb_hamming74_tx.sv
// Purpose: checks the Hamming(7,4) transmitter at IDLE_GAP 0 and 3 against a bit scoreboard and a corrector.
// Latency: expected bits are queued at accept and consumed as SOUT_VALID bits appear.
// Backpressure: the driver holds DIN_VALID until DIN_READY, so back-to-back and gapped traffic are both covered.
module tb_hamming74_tx;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  hamming74_tx_if if0 ();
  hamming74_tx_if if3 ();

  hamming74_tx #(.IDLE_GAP(0)) u0 (.CLK(CLK), .RESET(RESET), .bus(if0));
  hamming74_tx #(.IDLE_GAP(3)) u3 (.CLK(CLK), .RESET(RESET), .bus(if3));

  typedef struct packed {
    logic b;
    logic sof;
  } sb_t;

  typedef struct {
    logic [3:0] din;
    logic [2:0] inj;
    logic [1:7] code;
  } vec_t;

  sb_t q0[$];
  sb_t q3[$];

  int checks = 0;
  int errors = 0;

  // Monitor metrics.
  int cyc0 = 0;
  int run0 = 0;
  int max_run0 = 0;
  int last_sof0 = -1;
  int sof_gap0 = 0;
  int sof_cnt3 = 0;
  int both_low3 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:7] ref_code(input logic [3:0] d, input logic [2:0] inj);
    logic [1:7] c;
    c[3] = d[0];
    c[5] = d[1];
    c[6] = d[2];
    c[7] = d[3];
    c[1] = d[0] ^ d[1] ^ d[3];
    c[2] = d[0] ^ d[2] ^ d[3];
    c[4] = d[1] ^ d[2] ^ d[3];
    for (int i = 1; i <= 7; i++) begin
      if (inj == 3'(i)) c[i] = ~c[i];
    end
    return c;
  endfunction

  // Scoreboard for both instances, sampled on the falling edge.
  always @(negedge CLK) begin
    sb_t e;
    cyc0++;
    if (if0.SOUT_VALID) begin
      run0++;
      if (run0 > max_run0) max_run0 = run0;
      if (if0.SOF) begin
        if (last_sof0 >= 0) sof_gap0 = cyc0 - last_sof0;
        last_sof0 = cyc0;
      end
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u0_unexpected_bit: got sout=%0b with empty scoreboard", if0.SOUT);
      end else begin
        e = q0.pop_front();
        chk("u0_sout", 32'(if0.SOUT), 32'(e.b));
        chk("u0_sof", 32'(if0.SOF), 32'(e.sof));
      end
    end else begin
      run0 = 0;
      chk("u0_idle_sout_sof", {30'd0, if0.SOUT, if0.SOF}, 32'd0);
    end

    if (if3.SOUT_VALID) begin
      if (if3.SOF) sof_cnt3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u3_unexpected_bit: got sout=%0b with empty scoreboard", if3.SOUT);
      end else begin
        e = q3.pop_front();
        chk("u3_sout", 32'(if3.SOUT), 32'(e.b));
        chk("u3_sof", 32'(if3.SOF), 32'(e.sof));
      end
    end else begin
      if (!if3.DIN_READY && sof_cnt3 == 1) both_low3++;
      chk("u3_idle_sout_sof", {30'd0, if3.SOUT, if3.SOF}, 32'd0);
    end
  end

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    q0.delete();
    q3.delete();
    max_run0 = 0;
    last_sof0 = -1;
    sof_gap0 = 0;
    sof_cnt3 = 0;
    both_low3 = 0;
  endtask

  // Offer one word and return 1 ns after the accepting edge; DIN_VALID stays high.
  task automatic send(input int which, input logic [3:0] d, input logic [2:0] inj);
    logic [1:7] c;
    int n;
    c = ref_code(d, inj);
    if (which == 0) begin
      if0.DIN = d; if0.INJ_POS = inj; if0.DIN_VALID = 1'b1;
    end else begin
      if3.DIN = d; if3.INJ_POS = inj; if3.DIN_VALID = 1'b1;
    end
    n = 0;
    while (((which == 0) ? !if0.DIN_READY : !if3.DIN_READY) && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: DIN_READY low for %0d cycles, required high", n);
      return;
    end
    for (int i = 1; i <= 7; i++) begin
      if (which == 0) q0.push_back('{b: c[i], sof: (i == 1)});
      else            q3.push_back('{b: c[i], sof: (i == 1)});
    end
    @(posedge CLK);
    #1;
  endtask

  // Wait until the instance is idle with its scoreboard drained.
  task automatic drain(input int which);
    int n;
    n = 0;
    if (which == 0) if0.DIN_VALID = 1'b0;
    else            if3.DIN_VALID = 1'b0;
    while (n < 100 && ((which == 0) ?
           (q0.size() != 0 || if0.SOUT_VALID || !if0.DIN_READY) :
           (q3.size() != 0 || if3.SOUT_VALID || !if3.DIN_READY))) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: instance %0d not idle after %0d cycles", which, n);
    end
  endtask

  initial begin
    vec_t tbl[5];
    int exp_frames;
    logic [1:7] c;
    logic [1:7] cc;
    logic [2:0] s;

    tbl[0] = '{din: 4'b1011, inj: 3'd0, code: 7'b1010101};
    tbl[1] = '{din: 4'b0001, inj: 3'd5, code: 7'b1110100};
    tbl[2] = '{din: 4'b0001, inj: 3'd0, code: 7'b1110000};
    tbl[3] = '{din: 4'b0000, inj: 3'd0, code: 7'b0000000};
    tbl[4] = '{din: 4'b1111, inj: 3'd0, code: 7'b1111111};

    if0.DIN = '0; if0.INJ_POS = '0; if0.DIN_VALID = 1'b0;
    if3.DIN = '0; if3.INJ_POS = '0; if3.DIN_VALID = 1'b0;

    do_reset();

    // Reset state.
    chk("rst_ready0", 32'(if0.DIN_READY), 32'd1);
    chk("rst_vld0", 32'(if0.SOUT_VALID), 32'd0);
    chk("rst_code0", 32'(if0.CODE), 32'd0);
    chk("rst_frames0", 32'(if0.FRAMES), 32'd0);
    chk("rst_ready3", 32'(if3.DIN_READY), 32'd1);
    chk("rst_frames3", 32'(if3.FRAMES), 32'd0);

    // Single words from the table, one at a time.
    exp_frames = 0;
    for (int i = 0; i < 5; i++) begin
      send(0, tbl[i].din, tbl[i].inj);
      chk($sformatf("tbl%0d_code", i), 32'(if0.CODE), 32'(tbl[i].code));
      drain(0);
      exp_frames++;
      chk($sformatf("tbl%0d_frames", i), 32'(if0.FRAMES), 32'(exp_frames));
    end

    // Back-to-back at IDLE_GAP=0.
    do_reset();
    send(0, 4'b0000, 3'd0);
    send(0, 4'b1111, 3'd0);
    drain(0);
    chk("b2b_run", 32'(max_run0), 32'd14);
    chk("b2b_sof_gap", 32'(sof_gap0), 32'd7);
    chk("b2b_frames", 32'(if0.FRAMES), 32'd2);

    // IDLE_GAP=3 with continuous DIN_VALID.
    do_reset();
    send(3, 4'b1011, 3'd0);
    send(3, 4'b0110, 3'd0);
    drain(3);
    chk("gap_both_low", 32'(both_low3), 32'd3);
    chk("gap_frames", 32'(if3.FRAMES), 32'd2);

    // Reset during the 4th bit.
    do_reset();
    send(0, 4'b1011, 3'd0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    q0.delete();
    chk("midrst_vld", 32'(if0.SOUT_VALID), 32'd0);
    chk("midrst_frames", 32'(if0.FRAMES), 32'd0);
    chk("midrst_code", 32'(if0.CODE), 32'd0);
    chk("midrst_ready", 32'(if0.DIN_READY), 32'd1);
    RESET = 1'b0;
    send(0, 4'b0110, 3'd0);
    chk("midrst_new_code", 32'(if0.CODE), 32'(7'b1100110));
    drain(0);
    chk("midrst_new_frames", 32'(if0.FRAMES), 32'd1);

    // Exhaustive: every nibble and injection through a single-error corrector.
    for (int d = 0; d < 16; d++) begin
      for (int j = 0; j < 8; j++) begin
        send(0, 4'(d), 3'(j));
        c = if0.CODE;
        s = {c[4] ^ c[5] ^ c[6] ^ c[7], c[2] ^ c[3] ^ c[6] ^ c[7], c[1] ^ c[3] ^ c[5] ^ c[7]};
        cc = c;
        for (int k = 1; k <= 7; k++) begin
          if (s == 3'(k)) cc[k] = ~cc[k];
        end
        chk($sformatf("ex_d%0d_i%0d_nib", d, j), 32'({cc[7], cc[6], cc[5], cc[3]}), 32'(d));
        chk($sformatf("ex_d%0d_i%0d_syn", d, j), 32'(s), 32'(j));
        drain(0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
